// File: rtl/coherent_avg_fetch_if.sv
// Sample-in / sum-out bundle for the coherent averager; the master drives samples and control.
// Latency: none (plain wires between producer, averager and consumer).
// Backpressure: none; samples are offered with x_valid, sums stream out with y_valid.
interface coherent_avg_fetch_if #(
  parameter int Q = 32,
  parameter int M = 128,
  parameter int N = 16
);
  localparam int QO = Q + $clog2(N);
  localparam int IW = $clog2(M);

  logic                 start;
  logic                 abort;
  logic signed [Q-1:0]  x;
  logic                 x_valid;
  logic signed [QO-1:0] y;
  logic                 y_valid;
  logic [IW-1:0]        y_index;
  logic                 busy;
  logic                 done;

  modport master (
    output start, abort, x, x_valid,
    input  y, y_valid, y_index, busy, done
  );

  modport slave (
    input  start, abort, x, x_valid,
    output y, y_valid, y_index, busy, done
  );
endinterface

// File: rtl/coherent_avg_fetch.sv
// Coherent averager: sums N periods of M signed samples point by point, then streams the M sums.
// Latency: sample accepted at edge k lands in acc at k; sums appear 1..M edges after the last sample.
// Backpressure: none; x_valid gaps simply stall the counters, the readout cannot be throttled.
module coherent_avg_fetch #(
  parameter int Q = 32,
  parameter int M = 128,
  parameter int N = 16
) (
  input logic               clk,
  input logic               reset_n,
  coherent_avg_fetch_if.slave bus
);
  localparam int QO = Q + $clog2(N);
  localparam int IW = $clog2(M);
  localparam int FW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = IW + 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(M - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(N - 1);
  localparam logic [RW-1:0] RD_END   = RW'(M);

  typedef enum logic [1:0] {IDLE, ACCUM, DUMP} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [FW-1:0]        frm_q, frm_d;
  logic [RW-1:0]        rd_q, rd_d;
  logic signed [QO-1:0] y_q, y_d;
  logic [IW-1:0]        y_index_q, y_index_d;
  logic                 y_valid_q, y_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Accumulator array; contents are meaningless until frame 0 of a run overwrites them.
  logic signed [QO-1:0] acc_q [M];
  logic                 acc_we;
  logic [IW-1:0]        acc_wa;
  logic signed [QO-1:0] acc_wd;
  logic signed [QO-1:0] x_ext;

  assign x_ext = QO'($signed(bus.x));

  // Next-state, counter, accumulator-write and output logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frm_d     = frm_q;
    rd_d      = rd_q;
    y_d       = y_q;
    y_index_d = y_index_q;
    y_valid_d = 1'b0;
    done_d    = 1'b0;
    acc_we    = 1'b0;
    acc_wa    = idx_q;
    // Frame 0 overwrites so no clear pass is needed and aborted runs never leak.
    acc_wd    = (frm_q == '0) ? x_ext : acc_q[idx_q] + x_ext;

    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = ACCUM;
            idx_d   = '0;
            frm_d   = '0;
          end
        end
        ACCUM: begin
          if (bus.x_valid) begin
            acc_we = 1'b1;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              if (frm_q == FRM_LAST) begin
                frm_d   = '0;
                rd_d    = '0;
                state_d = DUMP;
              end else begin
                frm_d = frm_q + FW'(1);
              end
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        DUMP: begin
          if (rd_q == RD_END) begin
            state_d = IDLE;
            done_d  = 1'b1;
            rd_d    = '0;
          end else begin
            y_d       = acc_q[rd_q[IW-1:0]];
            y_index_d = rd_q[IW-1:0];
            y_valid_d = 1'b1;
            rd_d      = rd_q + RW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      frm_q     <= '0;
      rd_q      <= '0;
      y_q       <= '0;
      y_index_q <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      frm_q     <= frm_d;
      rd_q      <= rd_d;
      y_q       <= y_d;
      y_index_q <= y_index_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // One read-modify-write per accepted sample; storage needs no reset.
  always_ff @(posedge clk) begin
    if (acc_we) begin
      acc_q[acc_wa] <= acc_wd;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_index = y_index_q;
  assign bus.y_valid = y_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_coherent_avg_fetch.sv
// Bench for coherent_avg_fetch: table vectors, hand-written abort/reset sequences, random runs.
// Latency: checks the exact edge-by-edge readout timing after the last sample.
// Backpressure: none in the design; the bench inserts x_valid gaps and ignored samples.
module tb_coherent_avg_fetch;
  localparam int Q  = 16;
  localparam int M  = 8;
  localparam int N  = 4;
  localparam int NM = M * N;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  coherent_avg_fetch_if #(.Q(Q), .M(M), .N(N)) bus ();
  coherent_avg_fetch #(.Q(Q), .M(M), .N(N)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int     total  = 0;
  int     passed = 0;
  int     smp [NM];
  longint expv [M];

  typedef struct {
    int xval;
    bit ramp;
    int gap_max;
    bit start_mid;
    int exp_base;
    int exp_step;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: each output is the plain sum of that position over all periods.
  task automatic model();
    for (int i = 0; i < M; i++) begin
      longint s = 0;
      for (int f = 0; f < N; f++) s += smp[f * M + i];
      expv[i] = s;
    end
  endtask

  task automatic fill_random();
    for (int s = 0; s < NM; s++) smp[s] = int'($urandom_range(65535, 0)) - 32768;
  endtask

  task automatic do_run(input string tag, input int gap_max, input bit start_mid,
                        input int abort_at, input int reset_at);
    // samples offered in IDLE must be ignored
    for (int k = 0; k < 2; k++) begin
      bus.x_valid = 1'b1;
      bus.x = 16'sh7fff;
      @(negedge clk);
    end
    bus.start = 1'b1;
    bus.x = 16'sh1234;
    @(negedge clk);
    bus.start = 1'b0;
    bus.x_valid = 1'b0;
    check({tag, "_busy_start"}, longint'(bus.busy), 1);
    for (int s = 0; s < NM; s++) begin
      int g;
      g = int'($urandom_range(gap_max, 0));
      for (int k = 0; k < g; k++) begin
        bus.x_valid = 1'b0;
        bus.x = Q'($urandom);
        bus.start = start_mid && ($urandom_range(1, 0) == 1);
        @(negedge clk);
      end
      bus.start = 1'b0;
      bus.x_valid = 1'b1;
      bus.x = Q'(smp[s]);
      @(negedge clk);
    end
    // samples offered in DUMP must be ignored
    bus.x = Q'($urandom);
    check({tag, "_dump_entry_vld"}, longint'(bus.y_valid), 0);
    check({tag, "_dump_entry_busy"}, longint'(bus.busy), 1);
    for (int j = 1; j <= M; j++) begin
      @(negedge clk);
      check($sformatf("%s_vld%0d", tag, j - 1), longint'(bus.y_valid), 1);
      check($sformatf("%s_idx%0d", tag, j - 1), longint'(bus.y_index), j - 1);
      check($sformatf("%s_y%0d", tag, j - 1), longint'($signed(bus.y)), expv[j - 1]);
      if (j == abort_at) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.x_valid = 1'b0;
        check({tag, "_abort_vld"}, longint'(bus.y_valid), 0);
        check({tag, "_abort_busy"}, longint'(bus.busy), 0);
        check({tag, "_abort_done"}, longint'(bus.done), 0);
        @(negedge clk);
        check({tag, "_abort_done2"}, longint'(bus.done), 0);
        return;
      end
      if (j == reset_at) begin
        #2 reset_n = 1'b0;
        #1;
        check({tag, "_rst_vld"}, longint'(bus.y_valid), 0);
        check({tag, "_rst_busy"}, longint'(bus.busy), 0);
        check({tag, "_rst_done"}, longint'(bus.done), 0);
        check({tag, "_rst_y"}, longint'($signed(bus.y)), 0);
        check({tag, "_rst_idx"}, longint'(bus.y_index), 0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.x_valid = 1'b0;
        return;
      end
    end
    // start seen while still in DUMP must be ignored
    bus.start = start_mid;
    @(negedge clk);
    bus.start = 1'b0;
    bus.x_valid = 1'b0;
    check({tag, "_end_vld"}, longint'(bus.y_valid), 0);
    check({tag, "_end_done"}, longint'(bus.done), 1);
    check({tag, "_end_busy"}, longint'(bus.busy), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, longint'(bus.done), 0);
    check({tag, "_idle_busy"}, longint'(bus.busy), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.x = '0;
    bus.x_valid = 1'b0;

    vecs[0] = '{5,      1'b0, 0, 1'b0, 20,      0};
    vecs[1] = '{0,      1'b1, 0, 1'b0, 0,       4};
    vecs[2] = '{-32768, 1'b0, 0, 1'b0, -131072, 0};
    vecs[3] = '{32767,  1'b0, 0, 1'b0, 131068,  0};
    vecs[4] = '{5,      1'b0, 3, 1'b1, 20,      0};
    vecs[5] = '{-1,     1'b0, 1, 1'b1, -4,      0};

    #3;
    check("reset_vld", longint'(bus.y_valid), 0);
    check("reset_busy", longint'(bus.busy), 0);
    check("reset_done", longint'(bus.done), 0);
    check("reset_y", longint'($signed(bus.y)), 0);
    check("reset_idx", longint'(bus.y_index), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      for (int s = 0; s < NM; s++) smp[s] = vecs[k].ramp ? (s % M) : vecs[k].xval;
      for (int i = 0; i < M; i++) expv[i] = vecs[k].exp_base + vecs[k].exp_step * i;
      do_run($sformatf("vec%0d", k), vecs[k].gap_max, vecs[k].start_mid, 0, 0);
    end

    // abort in frame 2 after writing 100s, then rerun with 1s
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int s = 0; s < 2 * M + 3; s++) begin
      bus.x_valid = 1'b1;
      bus.x = 16'sd100;
      @(negedge clk);
    end
    bus.x_valid = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_f2_busy", longint'(bus.busy), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_f2_done%0d", k), longint'(bus.done), 0);
    end
    for (int s = 0; s < NM; s++) smp[s] = 1;
    for (int i = 0; i < M; i++) expv[i] = 4;
    do_run("rerun1", 0, 1'b0, 0, 0);

    // start with abort in IDLE: abort wins
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", longint'(bus.busy), 0);
    @(negedge clk);
    check("start_abort_busy2", longint'(bus.busy), 0);

    // abort during DUMP
    fill_random();
    model();
    do_run("abort_dump", 1, 1'b0, 3, 0);

    // asynchronous reset mid-DUMP, then a fresh run
    fill_random();
    model();
    do_run("rst_dump", 0, 1'b0, 0, 5);
    fill_random();
    model();
    do_run("after_rst", 2, 1'b1, 0, 0);

    for (int r = 0; r < 4; r++) begin
      fill_random();
      model();
      do_run($sformatf("rand%0d", r), 2, 1'b1, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
